// File: rtl/ram_test_pkg.sv
// Shared definitions for the dual-port test RAM pattern writer and read-back checker.
// Both sides import this package so their LFSR streams match by construction.
package ram_test_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 2048;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps x^16 + x^14 + x^13 + x^11 + 1 as bit positions 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load-to-seed and single-step advance.
// Shared by the pattern writer and the read-back checker.
module lfsr16
    import ram_test_pkg::*;
#(
    parameter logic [15:0] SEED  = LFSR_SEED,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [OUT_W-1:0] value
);

    logic [15:0] state_r;

    // Load has priority so a new sweep always starts from the seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SEED;
        end else if (load) begin
            state_r <= SEED;
        end else if (step) begin
            state_r <= lfsr_next(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign value = state_r[OUT_W-1:0];

endmodule

// File: rtl/ram_readback_checker.sv
// Port-B read-back checker: sweeps every RAM address once per start and compares
// each returned word against the regenerated LFSR stream.
module ram_readback_checker
    import ram_test_pkg::*;
#(
    parameter int          ADDR_W = ADDR_W_DEF,
    parameter int          DATA_W = DATA_W_DEF,
    parameter int          DEPTH  = DEPTH_DEF,
    parameter int          RD_LAT = 1,
    parameter logic [15:0] SEED   = LFSR_SEED
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              start,
    output logic              ram_enb,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [11:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT);
    localparam logic [11:0]       ERR_MAX    = 12'hFFF;

    state_e              state_r;
    logic [1:0]          drain_cnt_r;
    logic [RD_LAT-1:0]   vld_r;
    logic [ADDR_W-1:0]   tag_addr_r [RD_LAT];
    logic [DATA_W-1:0]   exp_word_s;
    logic                start_ok_s;
    logic                cmp_s;
    logic                miss_s;

    assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign cmp_s      = vld_r[RD_LAT-1];
    assign miss_s     = cmp_s && (ram_doutb != exp_word_s);

    lfsr16 #(
        .SEED  (SEED),
        .OUT_W (DATA_W)
    ) u_lfsr (
        .clk   (clk_50),
        .rst   (rst),
        .load  (start_ok_s),
        .step  (cmp_s),
        .value (exp_word_s)
    );

    // Sweep sequencer; DRAIN spans RD_LAT+1 cycles so the last compare settles before done
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ram_enb     <= 1'b0;
            ram_addrb   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            drain_cnt_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_READ;
                        ram_enb     <= 1'b1;
                        ram_addrb   <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        drain_cnt_r <= 2'd0;
                    end
                end
                ST_READ: begin
                    if (ram_addrb == LAST_ADDR) begin
                        state_r     <= ST_DRAIN;
                        ram_enb     <= 1'b0;
                        drain_cnt_r <= 2'd0;
                    end else begin
                        ram_addrb <= ram_addrb + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_cnt == 12'd0);
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ram_enb <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Valid/address tags travel alongside each read until its data returns
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            vld_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_addr_r[i] <= '0;
            end
        end else begin
            vld_r[0]      <= ram_enb;
            tag_addr_r[0] <= ram_addrb;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_r[i]      <= vld_r[i-1];
                tag_addr_r[i] <= tag_addr_r[i-1];
            end
        end
    end

    // Error accounting; a zero count marks that no mismatch has been captured yet
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            err_cnt        <= 12'd0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (start_ok_s) begin
            err_cnt        <= 12'd0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (miss_s) begin
            if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + 12'd1;
            end
            if (err_cnt == 12'd0) begin
                first_err_addr <= tag_addr_r[RD_LAT-1];
                first_err_data <= ram_doutb;
            end
        end
    end

endmodule
